// File: rtl/shift_out_pkg.sv
// Shared types and default sizing for the shift_out serial transmitter.
package shift_out_pkg;

    // Transfer sequencing: wait for a word, clock it out, strobe the storage register.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_e;

    localparam int DATA_W_DEF  = 8;
    localparam int CLK_DIV_DEF = 4;

endpackage : shift_out_pkg

// File: rtl/shift_out_sva.sv
// Protocol checks on the serial outputs: data is stable while the serial
// clock is high, and the latch strobe never overlaps a serial clock pulse.
module shift_out_sva (
    input logic i_clk,
    input logic i_rst_n,
    input logic i_sclk,
    input logic i_sdata,
    input logic i_latch
);

    // Serial data must hold for the whole high phase of the serial clock.
    property p_sdata_stable_high;
        @(posedge i_clk) disable iff (!i_rst_n)
            ($past(i_sclk) && i_sclk) |-> $stable(i_sdata);
    endproperty
    a_sdata_stable_high : assert property (p_sdata_stable_high);

    // Storage strobe and serial clock are mutually exclusive.
    property p_latch_sclk_excl;
        @(posedge i_clk) disable iff (!i_rst_n)
            !(i_latch && i_sclk);
    endproperty
    a_latch_sclk_excl : assert property (p_latch_sclk_excl);

endmodule : shift_out_sva

// File: rtl/shift_out_tick.sv
// Half-period tick generator: pulses o_tick on the last of every CLK_DIV
// enabled cycles. i_clr holds the count at zero so each transfer starts
// a fresh half-period.
module shift_out_tick
    import shift_out_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEF
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);

    localparam int                CNT_W    = $clog2(CLK_DIV + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             tick_s;

    // Tick fires on the final cycle of an enabled half-period.
    always_comb begin
        tick_s = 1'b0;
        if (i_en && (cnt_q == CNT_LAST)) begin
            tick_s = 1'b1;
        end else begin
            tick_s = 1'b0;
        end
    end

    // Next count: clear wins, otherwise count up and wrap after the last cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_en) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Divider count register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_tick = tick_s;

endmodule : shift_out_tick

// File: rtl/shift_out.sv
// Parallel-to-serial transmitter for a D-flip-flop shift-register chain with
// a storage-register strobe. Bits go out MSB first by default; defining
// SHIFT_OUT_LSB_FIRST_EN sends them LSB first with identical timing.
// The current bit is picked from the unchanging shadow word by a one-hot mask.
module shift_out
    import shift_out_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int CLK_DIV = CLK_DIV_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_ready,
    output logic              o_sclk,
    output logic              o_sdata,
    output logic              o_latch
);

    localparam int BIT_W = $clog2(DATA_W + 1);

`ifdef SHIFT_OUT_LSB_FIRST_EN
    localparam logic [DATA_W-1:0] MASK_FIRST = DATA_W'(1);
`else
    localparam logic [DATA_W-1:0] MASK_FIRST = (DATA_W'(1) << (DATA_W - 1));
`endif

    state_e            state_q;
    logic [DATA_W-1:0] shadow_q;
    logic [DATA_W-1:0] mask_q;
    logic [DATA_W-1:0] mask_d;
    logic [BIT_W-1:0]  bit_cnt_q;
    logic              ready_q;
    logic              sclk_q;
    logic              sdata_q;
    logic              latch_q;
    logic              tick_s;
    logic              tick_en_s;
    logic              tick_clr_s;
    logic              last_bit_s;

    // Divider runs only while a transfer is in flight and restarts from zero on acceptance.
    always_comb begin
        tick_en_s  = 1'b0;
        tick_clr_s = 1'b0;
        if (state_q == IDLE) begin
            tick_en_s  = 1'b0;
            tick_clr_s = 1'b1;
        end else begin
            tick_en_s  = 1'b1;
            tick_clr_s = 1'b0;
        end
    end

    shift_out_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (tick_en_s),
        .i_clr   (tick_clr_s),
        .o_tick  (tick_s)
    );

    // Advance the bit-select mask one position in transmit order.
    always_comb begin
        mask_d = mask_q;
`ifdef SHIFT_OUT_LSB_FIRST_EN
        mask_d = mask_q << 1;
`else
        mask_d = mask_q >> 1;
`endif
    end

    // The bit just clocked out is the final one of the word.
    always_comb begin
        last_bit_s = 1'b0;
        if (bit_cnt_q == BIT_W'(DATA_W - 1)) begin
            last_bit_s = 1'b1;
        end else begin
            last_bit_s = 1'b0;
        end
    end

    // Transfer FSM with all outputs registered.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            shadow_q  <= '0;
            mask_q    <= '0;
            bit_cnt_q <= '0;
            ready_q   <= 1'b1;
            sclk_q    <= 1'b0;
            sdata_q   <= 1'b0;
            latch_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    sclk_q  <= 1'b0;
                    latch_q <= 1'b0;
                    if (i_valid) begin
                        shadow_q  <= i_data;
                        mask_q    <= MASK_FIRST;
                        sdata_q   <= |(i_data & MASK_FIRST);
                        bit_cnt_q <= '0;
                        ready_q   <= 1'b0;
                        state_q   <= SHIFT;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (tick_s) begin
                        if (!sclk_q) begin
                            sclk_q <= 1'b1;
                        end else begin
                            // Falling phase: the only point where serial data may move.
                            sclk_q    <= 1'b0;
                            bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                            if (last_bit_s) begin
                                latch_q <= 1'b1;
                                state_q <= LATCH;
                            end else begin
                                mask_q  <= mask_d;
                                sdata_q <= |(shadow_q & mask_d);
                            end
                        end
                    end
                end
                LATCH: begin
                    if (tick_s) begin
                        latch_q <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    sclk_q  <= 1'b0;
                    latch_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_ready = ready_q;
    assign o_sclk  = sclk_q;
    assign o_sdata = sdata_q;
    assign o_latch = latch_q;

    shift_out_sva u_sva (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_sclk  (sclk_q),
        .i_sdata (sdata_q),
        .i_latch (latch_q)
    );

endmodule : shift_out

// File: doc/shift_out.md
SHIFT_OUT -- requirements
Module: shift_out

Interface
REQ-001 Parameter DATA_W, default 8: parallel word width in bits; SHALL be >= 1.
REQ-002 Parameter CLK_DIV, default 4: i_clk cycles per serial-clock half-period; SHALL be >= 1.
REQ-003 i_clk  input  1  single clock; all logic on rising edge.
REQ-004 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 i_valid  input  1  word offered for transmission.
REQ-006 i_data  input  DATA_W  word to transmit.
REQ-007 o_ready  output  1  block idle; a word is accepted this cycle if i_valid is high.
REQ-008 o_sclk  output  1  serial clock to the downstream D-flip-flop shift-register chain.
REQ-009 o_sdata  output  1  serial data; stable around every o_sclk rising edge.
REQ-010 o_latch  output  1  storage-register strobe, high after the last bit.

Function
REQ-011 FSM states SHALL be IDLE, SHIFT and LATCH.
REQ-012 IDLE: o_ready=1, o_sclk=0, o_latch=0; on i_valid=1 at a clock edge, capture i_data into a shadow register and enter SHIFT.
REQ-013 The captured word SHALL NOT change during a transfer; i_data/i_valid while not ready are ignored.
REQ-014 SHIFT: the default bit order SHALL be MSB first; o_sdata SHALL present the current bit for the whole bit period.
REQ-015 Each bit period SHALL be CLK_DIV cycles with o_sclk=0, then CLK_DIV cycles with o_sclk=1; the downstream chain samples on the o_sclk rise.
REQ-016 o_sdata SHALL update only on the cycle o_sclk returns 0, never while o_sclk=1.
REQ-017 After DATA_W bit periods, o_sclk=0 and the FSM SHALL enter LATCH.
REQ-018 LATCH: o_latch=1 for exactly CLK_DIV cycles, then the FSM SHALL return to IDLE.
REQ-019 Total occupancy from acceptance edge to o_ready high SHALL be 2*CLK_DIV*DATA_W + CLK_DIV cycles.
REQ-020 Back-to-back: if i_valid is high on the first IDLE cycle, the next word SHALL be accepted on that cycle, with no extra gap.
REQ-021 The bit counter SHALL be $clog2(DATA_W+1) bits wide and the divider counter $clog2(CLK_DIV+1) bits wide; neither counter shall wrap mid-transfer.
REQ-022 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-023 i_rst_n=0 SHALL force, asynchronously: FSM=IDLE, counters=0, shadow register=0, o_ready=1, o_sclk=0, o_sdata=0, o_latch=0.
REQ-024 Reset during SHIFT or LATCH SHALL abort the transfer with no o_latch pulse; the first edge after release SHALL behave as IDLE.

Configuration
REQ-025 With SHIFT_OUT_LSB_FIRST_EN defined, bits SHALL be sent LSB first; without it, MSB first. Timing is identical in both cases.

Structure
REQ-026 Package shift_out_pkg SHALL hold the FSM state enum typedef and the default DATA_W/CLK_DIV constants.
REQ-027 One sub-module, shift_out_tick, SHALL generate the half-period tick from CLK_DIV, with enable and synchronous clear.

Verification
REQ-028 DATA_W=8, CLK_DIV=2, send 8'hA5 -> o_sdata at successive o_sclk rises = 1,0,1,0,0,1,0,1; o_latch high 2 cycles; o_ready returns after 34 cycles.
REQ-029 Send 8'h3C, then hold i_valid with 8'hFF immediately -> second word accepted on the first o_ready cycle; a chain model reads 8'h3C, then 8'hFF.
REQ-030 During the 8'h3C transfer, change i_data to 8'h00 with i_valid=1 -> transmitted bits still 0,0,1,1,1,1,0,0.
REQ-031 Assert i_rst_n=0 after the 4th o_sclk rise of 8'hA5 -> all outputs take reset values asynchronously, no o_latch pulse; the next 8'h81 transfers correctly.
REQ-032 With SHIFT_OUT_LSB_FIRST_EN, CLK_DIV=1, send 8'h01 -> first bit 1, then seven 0s; occupancy 17 cycles.
REQ-033 Assertions: o_sdata never changes while o_sclk=1, and o_latch and o_sclk are never high together.
